// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: word width, FSM state encodings
// and a wrap-around increment helper.
package instruction_fetch_unit_pkg;

   localparam int WORD_W = 16;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_FAULT = 2'd3
   } ifu_state_t;

   // Sequential successor of a word address; wraps 0xFFFF -> 0x0000.
   function automatic word_t word_inc(input word_t a);
      word_inc = a + word_t'(1);
   endfunction

endpackage

// File: rtl/instruction_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection for an accepted instruction: jump beats branch,
// branch is relative to the sequential successor, all arithmetic mod 2^16.
module next_pc_calc
   import instruction_fetch_unit_pkg::*;
(
   input  logic [15:0] pc,
   input  logic        branch_take,
   input  logic [15:0] branch_offset,
   input  logic        jump_take,
   input  logic [15:0] jump_target,
   output logic [15:0] next_pc
);

   logic [15:0] seq_pc;

   always_comb begin
      seq_pc  = word_inc(pc);
      next_pc = seq_pc;
      if (jump_take) begin
         next_pc = jump_target;
      end else if (branch_take) begin
         next_pc = seq_pc + branch_offset;
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: req/ack memory fetch, valid/ready hand-off to decode, timeout fault.
// Optional accepted-instruction counter enabled by defining IFU_INSTR_COUNT_EN.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter logic [7:0]  MEM_TIMEOUT = 8'd255
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata,
   output logic [15:0] instr,
   output logic [7:0]  imm8,
   output logic [15:0] pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        branch_take,
   input  logic [15:0] branch_offset,
   input  logic        jump_take,
   input  logic [15:0] jump_target,
   output logic        fetch_fault
`ifdef IFU_INSTR_COUNT_EN
   ,
   output logic [15:0] instr_count
`endif
);

   ifu_state_t  state;
   ifu_state_t  state_next;
   logic [15:0] fetch_pc;
   logic [15:0] next_pc;
   logic [7:0]  wait_cnt;
   logic        load;
   logic        accept;

   next_pc_calc u_next_pc (
      .pc            (pc),
      .branch_take   (branch_take),
      .branch_offset (branch_offset),
      .jump_take     (jump_take),
      .jump_target   (jump_target),
      .next_pc       (next_pc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // An ack arriving in the same cycle the counter hits the limit still wins.
   always_comb begin
      state_next  = state;
      mem_req     = 1'b0;
      instr_valid = 1'b0;
      fetch_fault = 1'b0;
      load        = 1'b0;
      accept      = 1'b0;
      case (state)
         ST_IDLE: begin
            state_next = ST_FETCH;
         end
         ST_FETCH: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               load       = 1'b1;
               state_next = ST_HOLD;
            end else if (wait_cnt == MEM_TIMEOUT) begin
               state_next = ST_FAULT;
            end
         end
         ST_HOLD: begin
            instr_valid = 1'b1;
            if (instr_ready) begin
               accept     = 1'b1;
               state_next = ST_FETCH;
            end
         end
         ST_FAULT: begin
            fetch_fault = 1'b1;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // The wait counter is held at zero outside FETCH, so every fetch starts from zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         instr    <= '0;
         pc       <= '0;
         wait_cnt <= '0;
      end else begin
         if (load) begin
            instr <= mem_rdata;
            pc    <= fetch_pc;
         end
         if (accept) begin
            fetch_pc <= next_pc;
         end
         if (state == ST_FETCH && !mem_ack) begin
            wait_cnt <= wait_cnt + 8'd1;
         end else begin
            wait_cnt <= '0;
         end
      end
   end

`ifdef IFU_INSTR_COUNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_count <= '0;
      end else if (accept) begin
         instr_count <= instr_count + 16'd1;
      end
   end
`endif

   assign mem_addr = fetch_pc;
   assign imm8     = instr[7:0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: expected fetch addresses and delivered
// instructions are queued by the stimulus and popped by independent monitors.
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        resp_ack = 1'b0;
   logic        late_ack = 1'b0;
   logic [15:0] resp_rdata = '0;
   logic [15:0] late_rdata = '0;
   logic [15:0] instr;
   logic [7:0]  imm8;
   logic [15:0] pc;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic        branch_take = 1'b0;
   logic [15:0] branch_offset = '0;
   logic        jump_take = 1'b0;
   logic [15:0] jump_target = '0;
   logic        fetch_fault;
`ifdef IFU_INSTR_COUNT_EN
   logic [15:0] instr_count;
`endif

   int errors = 0;
   int checks = 0;
   logic resp_en = 1'b1;
   int   wait_cycles = 2;
   int   wcnt = 0;
   logic prev_req = 1'b0;
   logic [15:0] addr_q[$];
   logic [31:0] item_q[$];

   always #5 clk = ~clk;

   instruction_fetch_unit #(
      .RESET_PC    (16'h0000),
      .MEM_TIMEOUT (8'd4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_ack       (resp_ack | late_ack),
      .mem_rdata     (late_ack ? late_rdata : resp_rdata),
      .instr         (instr),
      .imm8          (imm8),
      .pc            (pc),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .branch_take   (branch_take),
      .branch_offset (branch_offset),
      .jump_take     (jump_take),
      .jump_target   (jump_target),
      .fetch_fault   (fetch_fault)
`ifdef IFU_INSTR_COUNT_EN
      ,
      .instr_count   (instr_count)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      case (a)
         16'h0000: mem_word = 16'h12F0;
         16'h0001: mem_word = 16'hA55A;
         16'h0010: mem_word = 16'h0B7F;
         16'h4000: mem_word = 16'hC381;
         16'hFFFF: mem_word = 16'h7E80;
         default:  mem_word = 16'hDEAD;
      endcase
   endfunction

   // Memory model: acks after wait_cycles request cycles, data valid with the ack.
   always @(posedge clk) begin
      #1;
      if (resp_en && mem_req && !resp_ack) begin
         if (wcnt == wait_cycles) begin
            resp_ack   = 1'b1;
            resp_rdata = mem_word(mem_addr);
         end else begin
            wcnt++;
         end
      end else begin
         resp_ack = 1'b0;
         wcnt     = 0;
      end
   end

   // Fetch-address monitor: every new request is checked against the next expected address.
   always @(negedge clk) begin
      if (mem_req && !prev_req) begin
         if (addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL fetch_addr: unexpected fetch at 0x%0h, required none", mem_addr);
         end else begin
            chk("fetch_addr", {16'h0, mem_addr}, {16'h0, addr_q.pop_front()});
         end
      end
      prev_req = mem_req;
   end

   // Delivery monitor: every accepted instruction is checked against the scoreboard.
   always @(negedge clk) begin
      if (instr_valid && instr_ready) begin
         if (item_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL accept: unexpected instr 0x%0h at pc 0x%0h, required none", instr, pc);
         end else begin
            logic [31:0] e;
            e = item_q.pop_front();
            chk("acc_instr", {16'h0, instr}, {16'h0, e[31:16]});
            chk("acc_pc",    {16'h0, pc},    {16'h0, e[15:0]});
            chk("acc_imm8",  {24'h0, imm8},  {24'h0, e[23:16]});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!instr_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!instr_valid) begin
         checks++;
         errors++;
         $display("FAIL %s: instr_valid timeout got 0 required 1", name);
      end
   endtask

   task automatic accept(input logic [15:0] e_instr, input logic [15:0] e_pc,
                         input logic b, input logic [15:0] bo,
                         input logic j, input logic [15:0] jta,
                         input logic [15:0] e_next);
      item_q.push_back({e_instr, e_pc});
      addr_q.push_back(e_next);
      wait_valid("accept_wait");
      tick();
      instr_ready = 1'b1; branch_take = b; branch_offset = bo; jump_take = j; jump_target = jta;
      tick();
      instr_ready = 1'b0; branch_take = 1'b0; branch_offset = '0; jump_take = 1'b0; jump_target = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int req_cycles;
      addr_q.push_back(16'h0000);

      // T1: reset held three cycles
      repeat (3) begin
         tick();
         chk("rst_req", {31'h0, mem_req}, 32'h0);
      end
      chk("rst_instr", {16'h0, instr}, 32'h0);
      chk("rst_pc", {16'h0, pc}, 32'h0);
      chk("rst_valid", {31'h0, instr_valid}, 32'h0);
      chk("rst_fault", {31'h0, fetch_fault}, 32'h0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_req", {31'h0, mem_req}, 32'h0);
      @(negedge clk);
      chk("fetch_req", {31'h0, mem_req}, 32'h1);
      chk("fetch_addr0", {16'h0, mem_addr}, 32'h0);

      // T2: two wait cycles, then valid one cycle after the ack
      n = 0;
      while (!resp_ack && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ack_seen", {31'h0, resp_ack}, 32'h1);
      chk("ack_wait_cycles", n, 32'd2);
      chk("valid_at_ack", {31'h0, instr_valid}, 32'h0);
      @(negedge clk);
      chk("valid_after_ack", {31'h0, instr_valid}, 32'h1);
      chk("t2_instr", {16'h0, instr}, 32'h12F0);
      chk("t2_imm8", {24'h0, imm8}, 32'hF0);
      chk("t2_pc", {16'h0, pc}, 32'h0);
      chk("t2_hold_req", {31'h0, mem_req}, 32'h0);
      accept(16'h12F0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0001);

      // T3: jump into 0x0010, branch back to 0x0001, jump beating branch
      accept(16'hA55A, 16'h0001, 1'b0, 16'h0000, 1'b1, 16'h0010, 16'h0010);
      accept(16'h0B7F, 16'h0010, 1'b1, 16'hFFF0, 1'b0, 16'h0000, 16'h0001);
      accept(16'hA55A, 16'h0001, 1'b1, 16'hFFF0, 1'b1, 16'h4000, 16'h4000);
      accept(16'hC381, 16'h4000, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 16'hFFFF);

      // T4: backpressure at 0xFFFF with branch/jump asserted but not accepted
      wait_valid("t4_wait");
      tick();
      branch_take = 1'b1; branch_offset = 16'h0005; jump_take = 1'b1; jump_target = 16'h1234;
      repeat (5) begin
         @(negedge clk);
         chk("bp_instr", {16'h0, instr}, 32'h7E80);
         chk("bp_pc", {16'h0, pc}, 32'hFFFF);
         chk("bp_req", {31'h0, mem_req}, 32'h0);
         chk("bp_valid", {31'h0, instr_valid}, 32'h1);
      end
      tick();
      branch_take = 1'b0; branch_offset = '0; jump_take = 1'b0; jump_target = '0;
      accept(16'h7E80, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
      accept(16'h12F0, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 16'h0000, 16'hFFFF);

      // T6: reset while waiting on a fetch at 0x0023
      wait_valid("t6_wait");
      resp_en = 1'b0;
      accept(16'h7E80, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 16'h0023, 16'h0023);
      repeat (2) begin
         @(negedge clk);
         chk("t6_req", {31'h0, mem_req}, 32'h1);
         chk("t6_addr", {16'h0, mem_addr}, 32'h0023);
      end
      tick();
      reset = 1'b1;
      addr_q.push_back(16'h0000);
      tick();
      @(negedge clk);
      chk("t6_rst_req", {31'h0, mem_req}, 32'h0);
      chk("t6_rst_valid", {31'h0, instr_valid}, 32'h0);
      chk("t6_rst_pc", {16'h0, pc}, 32'h0);
`ifdef IFU_INSTR_COUNT_EN
      chk("cnt_reset", {16'h0, instr_count}, 32'h0);
`endif
      tick();
      reset = 1'b0;
      resp_en = 1'b1;
      accept(16'h12F0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0001);
      accept(16'hA55A, 16'h0001, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0002);
      accept(16'hDEAD, 16'h0002, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0003);
`ifdef IFU_INSTR_COUNT_EN
      @(negedge clk);
      chk("cnt_three", {16'h0, instr_count}, 32'h3);
`endif

      // T5: memory never acks -> sticky fault
      tick();
      resp_en = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      addr_q.push_back(16'h0000);
      reset = 1'b0;
      n = 0;
      req_cycles = 0;
      while (!fetch_fault && n < 30) begin
         @(negedge clk);
         if (mem_req) req_cycles++;
         n++;
      end
      chk("fault_set", {31'h0, fetch_fault}, 32'h1);
      chk("fault_req", {31'h0, mem_req}, 32'h0);
      chk("fault_valid", {31'h0, instr_valid}, 32'h0);
      chk("fault_wait_len", {31'h0, (req_cycles >= 4 && req_cycles <= 5)}, 32'h1);
      tick();
      late_ack = 1'b1;
      late_rdata = 16'h1111;
      repeat (3) begin
         @(negedge clk);
         chk("late_fault", {31'h0, fetch_fault}, 32'h1);
         chk("late_valid", {31'h0, instr_valid}, 32'h0);
         chk("late_req", {31'h0, mem_req}, 32'h0);
         chk("late_instr", {16'h0, instr}, 32'h0);
      end
      tick();
      late_ack = 1'b0;
      reset = 1'b1;
      addr_q.push_back(16'h0000);
      tick();
      reset = 1'b0;
      resp_en = 1'b1;
      @(negedge clk);
      chk("fault_cleared", {31'h0, fetch_fault}, 32'h0);
      accept(16'h12F0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0001);
      repeat (6) @(negedge clk);

      chk("addr_q_empty", addr_q.size(), 32'h0);
      chk("item_q_empty", item_q.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
